// File: rtl/motor_pwm_driver.sv
// H-bridge driver for the left/right drive motors: shared PWM counter, per-motor IDLE/RUN/BRAKE FSM with coast dead time.
// Optional build macro SOFT_RAMP_EN: duty slews toward the target by RAMP_STEP per PWM period instead of loading directly.

module motor_pwm_channel #(
    parameter int              CW      = 12,
    parameter int              DW      = 16,
    parameter logic [DW-1:0]   DT_LOAD = '0,
    parameter logic [CW-1:0]   STEP    = '1
) (
    input  logic          clk_50,
    input  logic          rst_n,
    input  logic [1:0]    tgt_dir,   // {minus, plus}; 2'b00 = stop
    input  logic [CW-1:0] tgt_duty,
    input  logic [CW-1:0] cnt,
    input  logic          boundary,
    output logic          in1,
    output logic          in2,
    output logic          en,
    output logic          brk
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_BRAKE} state_t;

    state_t        state_q, state_d;
    logic          rev_q, rev_d;
    logic [DW-1:0] dt_q, dt_d;
    logic [CW-1:0] duty_q, duty_d;
    logic [CW-1:0] ramp_duty;
    logic          same_dir;

    always_comb begin
        same_dir = rev_q ? (tgt_dir == 2'b10) : (tgt_dir == 2'b01);
    end

    // With direct loading STEP is clamped to the full period, so one step always reaches the target.
    always_comb begin
        ramp_duty = duty_q;
        if (tgt_duty > duty_q)
            ramp_duty = ((tgt_duty - duty_q) > STEP) ? duty_q + STEP : tgt_duty;
        else if (tgt_duty < duty_q)
            ramp_duty = ((duty_q - tgt_duty) > STEP) ? duty_q - STEP : tgt_duty;
    end

    always_comb begin
        state_d = state_q;
        rev_d   = rev_q;
        dt_d    = dt_q;
        case (state_q)
            S_IDLE: begin
                if (tgt_dir != 2'b00) begin
                    state_d = S_RUN;
                    rev_d   = tgt_dir[1];
                end
            end
            S_RUN: begin
                if (!same_dir) begin
                    state_d = S_BRAKE;
                    dt_d    = DT_LOAD;
                end
            end
            S_BRAKE: begin
                if (dt_q == '0) begin
                    if (tgt_dir != 2'b00) begin
                        state_d = S_RUN;
                        rev_d   = tgt_dir[1];
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    dt_d = dt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A fresh RUN keeps duty 0 until the first boundary seen while already running.
    always_comb begin
        duty_d = duty_q;
        if (state_d != S_RUN)
            duty_d = '0;
        else if (state_q == S_RUN && boundary)
            duty_d = ramp_duty;
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rev_q   <= 1'b0;
            dt_q    <= '0;
            duty_q  <= '0;
        end else begin
            state_q <= state_d;
            rev_q   <= rev_d;
            dt_q    <= dt_d;
            duty_q  <= duty_d;
        end
    end

    assign in1 = (state_q == S_RUN) && !rev_q;
    assign in2 = (state_q == S_RUN) &&  rev_q;
    assign en  = (state_q == S_RUN) && (cnt < duty_q);
    assign brk = (state_q == S_BRAKE);

endmodule

module motor_pwm_driver #(
    parameter int PWM_PERIOD      = 2500,
    parameter int DEADTIME_CYCLES = 50000,
    parameter int RAMP_STEP       = 125
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic [2:0] drive_state,
    input  logic [1:0] speed,
    output logic       mL_in1,
    output logic       mL_in2,
    output logic       mL_en,
    output logic       mR_in1,
    output logic       mR_in2,
    output logic       mR_en,
    output logic       braking
);

    localparam int CW = $clog2(PWM_PERIOD + 1);
    localparam int DW = (DEADTIME_CYCLES > 1) ? $clog2(DEADTIME_CYCLES) : 1;
`ifdef SOFT_RAMP_EN
    localparam bit RAMP_ON = 1'b1;
`else
    localparam bit RAMP_ON = 1'b0;
`endif
    localparam int STEP_C = (!RAMP_ON || RAMP_STEP > PWM_PERIOD) ? PWM_PERIOD : RAMP_STEP;

    logic [2:0]      ds_q, ds_d;
    logic [1:0]      spd_q, spd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            boundary;
    logic [1:0][1:0] tgt_dir;   // [motor: 0 = left, 1 = right]
    logic [CW-1:0]   tgt_duty;
    logic [1:0]      in1, in2, en, brk;

    assign boundary = (cnt_q == CW'(PWM_PERIOD - 1));

    always_comb begin
        ds_d  = drive_state;
        spd_d = speed;
        cnt_d = boundary ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            ds_q  <= 3'd0;
            spd_q <= 2'd0;
            cnt_q <= '0;
        end else begin
            ds_q  <= ds_d;
            spd_q <= spd_d;
            cnt_q <= cnt_d;
        end
    end

    // Codes 5..7 fall through to stop.
    always_comb begin
        tgt_dir = '0;
        case (ds_q)
            3'd1:    tgt_dir = {2'b01, 2'b01};
            3'd2:    tgt_dir = {2'b10, 2'b10};
            3'd3:    tgt_dir = {2'b01, 2'b10};
            3'd4:    tgt_dir = {2'b10, 2'b01};
            default: tgt_dir = '0;
        endcase
    end

    always_comb begin
        tgt_duty = '0;
        case (spd_q)
            2'd1:    tgt_duty = CW'(PWM_PERIOD / 2);
            2'd2:    tgt_duty = CW'((3 * PWM_PERIOD) / 4);
            2'd3:    tgt_duty = CW'(PWM_PERIOD);
            default: tgt_duty = '0;
        endcase
    end

    for (genvar m = 0; m < 2; m++) begin : g_mot
        motor_pwm_channel #(
            .CW      (CW),
            .DW      (DW),
            .DT_LOAD (DW'(DEADTIME_CYCLES - 1)),
            .STEP    (CW'(STEP_C))
        ) u_ch (
            .clk_50   (clk_50),
            .rst_n    (rst_n),
            .tgt_dir  (tgt_dir[m]),
            .tgt_duty (tgt_duty),
            .cnt      (cnt_q),
            .boundary (boundary),
            .in1      (in1[m]),
            .in2      (in2[m]),
            .en       (en[m]),
            .brk      (brk[m])
        );
    end

    assign mL_in1  = in1[0];
    assign mL_in2  = in2[0];
    assign mL_en   = en[0];
    assign mR_in1  = in1[1];
    assign mR_in2  = in2[1];
    assign mR_en   = en[1];
    assign braking = |brk;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Scoreboard bench for motor_pwm_driver with shortened period/dead time; honours SOFT_RAMP_EN when defined.

module tb_motor_pwm_driver;

    localparam int P    = 40;
    localparam int DT   = 100;
    localparam int STEP = 5;
`ifdef SOFT_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif

    typedef logic [31:0] word_t;
    typedef struct {
        string name;
        int    val;
    } exp_t;

    logic       clk_50 = 1'b0;
    logic       rst_n  = 1'b0;
    logic [2:0] drive_state = 3'd0;
    logic [1:0] speed = 2'd0;
    logic       mL_in1, mL_in2, mL_en, mR_in1, mR_in2, mR_en, braking;

    exp_t  sb[$];
    word_t obs[$];
    int    checks = 0;
    int    errors = 0;
    int    illegal = 0;
    int    direct = 0;
    logic [1:0] prev_l = 2'b00, prev_r = 2'b00;

    always #10 clk_50 = ~clk_50;

    motor_pwm_driver #(
        .PWM_PERIOD      (P),
        .DEADTIME_CYCLES (DT),
        .RAMP_STEP       (STEP)
    ) dut (
        .clk_50      (clk_50),
        .rst_n       (rst_n),
        .drive_state (drive_state),
        .speed       (speed),
        .mL_in1      (mL_in1),
        .mL_in2      (mL_in2),
        .mL_en       (mL_en),
        .mR_in1      (mR_in1),
        .mR_in2      (mR_in2),
        .mR_en       (mR_en),
        .braking     (braking)
    );

    // Continuous watch for shoot-through and direct reversal.
    always @(negedge clk_50) begin
        if (!rst_n) begin
            prev_l = 2'b00;
            prev_r = 2'b00;
        end else begin
            if (mL_in1 && mL_in2) illegal++;
            if (mR_in1 && mR_in2) illegal++;
            if ((prev_l == 2'b10 && {mL_in1, mL_in2} == 2'b01) ||
                (prev_l == 2'b01 && {mL_in1, mL_in2} == 2'b10)) direct++;
            if ((prev_r == 2'b10 && {mR_in1, mR_in2} == 2'b01) ||
                (prev_r == 2'b01 && {mR_in1, mR_in2} == 2'b10)) direct++;
            prev_l = {mL_in1, mL_in2};
            prev_r = {mR_in1, mR_in2};
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog expired: simulation did not finish");
        $fatal(1);
    end

    function automatic word_t pins();
        return {28'd0, mL_in1, mL_in2, mR_in1, mR_in2};
    endfunction

    function automatic word_t outs();
        return {25'd0, mL_in1, mL_in2, mL_en, mR_in1, mR_in2, mR_en, braking};
    endfunction

    task automatic drive(input logic [2:0] ds, input logic [1:0] sp);
        @(negedge clk_50);
        drive_state = ds;
        speed       = sp;
    endtask

    task automatic count_en(input int n, output int cl, output int cr);
        cl = 0;
        cr = 0;
        repeat (n) begin
            @(negedge clk_50);
            if (mL_en) cl++;
            if (mR_en) cr++;
        end
    endtask

    // Returns negedges until braking rises, its length, and cycles with any pin/en active meanwhile.
    task automatic brake_measure(input bit toggle, output int lat, output int len, output int dirty);
        lat   = -1;
        len   = 0;
        dirty = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk_50);
            if (braking === 1'b1) begin
                lat = i;
                break;
            end
        end
        if (lat > 0) begin
            while (braking === 1'b1 && len < DT + 20) begin
                len++;
                if ((outs() >> 1) != 0) dirty++;
                if (toggle) begin
                    if (len == 10)      drive_state = 3'd2;
                    else if (len == 20) drive_state = 3'd1;
                    else if (len == 30) drive_state = 3'd0;
                end
                @(negedge clk_50);
            end
        end
    endtask

    task automatic sync_en_rise(output bit found);
        logic prev;
        found = 1'b0;
        prev  = mL_en;
        for (int i = 0; i < 3 * P; i++) begin
            @(negedge clk_50);
            if (mL_en && !prev) begin
                found = 1'b1;
                break;
            end
            prev = mL_en;
        end
    endtask

    task automatic test_reset();
        exp_t  e;
        word_t o;
        rst_n = 1'b0;
        sb.push_back('{"reset_outputs", 0});
        repeat (3) @(negedge clk_50);
        obs.push_back(outs());
        rst_n = 1'b1;
        sb.push_back('{"idle_after_release", 0});
        repeat (3) @(negedge clk_50);
        obs.push_back(outs());
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (obs.size() > 0) o = obs.pop_front(); else o = 'x;
            checks++;
            if (o !== word_t'(e.val)) begin
                errors++;
                $display("FAIL %s got %0d expected %0d", e.name, o, e.val);
            end
        end
        obs.delete();
    endtask

    task automatic test_fwd();
        exp_t  e;
        word_t o;
        int    cl, cr;
        sb.push_back('{"fwd_pins_cycle1", 0});
        sb.push_back('{"fwd_pins_cycle2", 4'b1010});
        sb.push_back('{"fwd_en_left_spd2", (3 * P) / 4});
        sb.push_back('{"fwd_en_right_spd2", (3 * P) / 4});
        sb.push_back('{"fwd_pins_steady", 4'b1010});
        drive(3'd1, 2'd2);
        @(negedge clk_50);
        obs.push_back(pins());
        @(negedge clk_50);
        obs.push_back(pins());
        repeat (8 * P) @(negedge clk_50);
        count_en(P, cl, cr);
        obs.push_back(cl);
        obs.push_back(cr);
        obs.push_back(pins());
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (obs.size() > 0) o = obs.pop_front(); else o = 'x;
            checks++;
            if (o !== word_t'(e.val)) begin
                errors++;
                $display("FAIL %s got %0d expected %0d", e.name, o, e.val);
            end
        end
        obs.delete();
    endtask

    task automatic test_fwd_to_rev();
        exp_t  e;
        word_t o;
        int    lat, len, dirty, cl, cr;
        sb.push_back('{"rev_brake_latency", 2});
        sb.push_back('{"rev_brake_length", DT});
        sb.push_back('{"rev_pins_during_brake", 0});
        sb.push_back('{"rev_pins_first_run", 4'b0101});
        sb.push_back('{"rev_en_first_run", 0});
        sb.push_back('{"rev_en_left_spd1", P / 2});
        sb.push_back('{"rev_en_right_spd1", P / 2});
        drive(3'd2, 2'd1);
        brake_measure(1'b0, lat, len, dirty);
        obs.push_back(lat);
        obs.push_back(len);
        obs.push_back(dirty);
        obs.push_back(pins());
        obs.push_back({30'd0, mL_en, mR_en});
        repeat (8 * P) @(negedge clk_50);
        count_en(P, cl, cr);
        obs.push_back(cl);
        obs.push_back(cr);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (obs.size() > 0) o = obs.pop_front(); else o = 'x;
            checks++;
            if (o !== word_t'(e.val)) begin
                errors++;
                $display("FAIL %s got %0d expected %0d", e.name, o, e.val);
            end
        end
        obs.delete();
    endtask

    task automatic test_fwd_to_left();
        exp_t  e;
        word_t o;
        int    brk, lcoast, rfwd, ren;
        drive(3'd1, 2'd1);
        repeat (DT + 8 * P) @(negedge clk_50);
        sb.push_back('{"left_braking_cycles", DT});
        sb.push_back('{"left_coast_cycles", DT});
        sb.push_back('{"right_fwd_cycles", 3 * P});
        sb.push_back('{"right_en_uninterrupted", 3 * (P / 2)});
        sb.push_back('{"left_rev_pins", 2'b01});
        drive(3'd3, 2'd1);
        brk = 0; lcoast = 0; rfwd = 0; ren = 0;
        repeat (3 * P) begin
            @(negedge clk_50);
            if (braking) brk++;
            if (!mL_in1 && !mL_in2) lcoast++;
            if (mR_in1 && !mR_in2) rfwd++;
            if (mR_en) ren++;
        end
        obs.push_back(brk);
        obs.push_back(lcoast);
        obs.push_back(rfwd);
        obs.push_back(ren);
        obs.push_back({30'd0, mL_in1, mL_in2});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (obs.size() > 0) o = obs.pop_front(); else o = 'x;
            checks++;
            if (o !== word_t'(e.val)) begin
                errors++;
                $display("FAIL %s got %0d expected %0d", e.name, o, e.val);
            end
        end
        obs.delete();
    endtask

    task automatic test_brake_toggle();
        exp_t  e;
        word_t o;
        int    lat, len, dirty, quiet;
        sb.push_back('{"toggle_brake_latency", 2});
        sb.push_back('{"toggle_brake_length", DT});
        sb.push_back('{"toggle_pins_during_brake", 0});
        sb.push_back('{"toggle_outputs_at_expiry", 0});
        sb.push_back('{"toggle_idle_quiet", 0});
        drive(3'd0, 2'd1);
        brake_measure(1'b1, lat, len, dirty);
        obs.push_back(lat);
        obs.push_back(len);
        obs.push_back(dirty);
        obs.push_back(outs());
        quiet = 0;
        repeat (2 * P) begin
            @(negedge clk_50);
            if (outs() != 0) quiet++;
        end
        obs.push_back(quiet);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (obs.size() > 0) o = obs.pop_front(); else o = 'x;
            checks++;
            if (o !== word_t'(e.val)) begin
                errors++;
                $display("FAIL %s got %0d expected %0d", e.name, o, e.val);
            end
        end
        obs.delete();
    endtask

    task automatic test_speed_change();
        exp_t  e;
        word_t o;
        int    cl, cr, c;
        bit    found;
        sb.push_back('{"spd_base_duty", P / 2});
        sb.push_back('{"spd_sync_found", 1});
        sb.push_back('{"spd_period_of_change", P / 2});
        sb.push_back('{"spd_next_two_periods", RAMP ? (P / 2 + STEP) + (P / 2 + 2 * STEP) : 2 * P});
        drive(3'd1, 2'd1);
        repeat (8 * P) @(negedge clk_50);
        count_en(P, cl, cr);
        obs.push_back(cl);
        sync_en_rise(found);
        obs.push_back({31'd0, found});
        c = 0;
        for (int i = 0; i < P; i++) begin
            if (i > 0) @(negedge clk_50);
            if (mL_en) c++;
            if (i == 5) speed = 2'd3;
        end
        obs.push_back(c);
        count_en(2 * P, cl, cr);
        obs.push_back(cl);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (obs.size() > 0) o = obs.pop_front(); else o = 'x;
            checks++;
            if (o !== word_t'(e.val)) begin
                errors++;
                $display("FAIL %s got %0d expected %0d", e.name, o, e.val);
            end
        end
        obs.delete();
    endtask

    task automatic test_ramp();
        exp_t  e;
        word_t o;
        int    c;
        bit    found;
        drive(3'd0, 2'd1);
        repeat (DT + 2 * P) @(negedge clk_50);
        sb.push_back('{"ramp_sync_found", 1});
        for (int k = 1; k <= 10; k++)
            sb.push_back('{$sformatf("ramp_period_%0d", k), RAMP ? ((STEP * k < P) ? STEP * k : P) : P});
        drive(3'd1, 2'd3);
        sync_en_rise(found);
        obs.push_back({31'd0, found});
        for (int k = 1; k <= 10; k++) begin
            c = 0;
            repeat (P) begin
                if (mL_en) c++;
                @(negedge clk_50);
            end
            obs.push_back(c);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (obs.size() > 0) o = obs.pop_front(); else o = 'x;
            checks++;
            if (o !== word_t'(e.val)) begin
                errors++;
                $display("FAIL %s got %0d expected %0d", e.name, o, e.val);
            end
        end
        obs.delete();
    endtask

    task automatic test_stop6_reset();
        exp_t  e;
        word_t o;
        int    lat, quiet;
        sb.push_back('{"code6_brake_latency", 2});
        sb.push_back('{"code6_still_braking", 1});
        sb.push_back('{"async_reset_outputs", 0});
        sb.push_back('{"post_reset_quiet", 0});
        sb.push_back('{"post_reset_restart", 4'b1010});
        drive(3'd6, 2'd3);
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk_50);
            if (braking === 1'b1) begin
                lat = i;
                break;
            end
        end
        obs.push_back(lat);
        repeat (30) @(negedge clk_50);
        obs.push_back({31'd0, braking});
        #3;
        rst_n = 1'b0;
        #1;
        obs.push_back(outs());
        repeat (3) @(negedge clk_50);
        rst_n = 1'b1;
        quiet = 0;
        repeat (2 * P) begin
            @(negedge clk_50);
            if (outs() != 0) quiet++;
        end
        obs.push_back(quiet);
        drive(3'd1, 2'd2);
        repeat (2) @(negedge clk_50);
        obs.push_back(pins());
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (obs.size() > 0) o = obs.pop_front(); else o = 'x;
            checks++;
            if (o !== word_t'(e.val)) begin
                errors++;
                $display("FAIL %s got %0d expected %0d", e.name, o, e.val);
            end
        end
        obs.delete();
    endtask

    task automatic test_invariants();
        exp_t  e;
        word_t o;
        sb.push_back('{"pins_both_high_cycles", 0});
        sb.push_back('{"direct_reversal_cycles", 0});
        obs.push_back(illegal);
        obs.push_back(direct);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (obs.size() > 0) o = obs.pop_front(); else o = 'x;
            checks++;
            if (o !== word_t'(e.val)) begin
                errors++;
                $display("FAIL %s got %0d expected %0d", e.name, o, e.val);
            end
        end
        obs.delete();
    endtask

    initial begin
        test_reset();
        test_fwd();
        test_fwd_to_rev();
        test_fwd_to_left();
        test_brake_toggle();
        test_speed_change();
        test_ramp();
        test_stop6_reset();
        test_invariants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
